clken_pll: RTL and testbench

CLKEN_PLL -- requirements
Module: clken_pll

---
 rtl/clken_pll_pkg.sv | 18 +
 rtl/clken_pll_chan.sv | 75 +++++++
 rtl/clken_pll.sv | 132 +++++++++++++
 tb/tb_clken_pll.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clken_pll_pkg.sv
// Shared types and address-map constants for the clken_pll clock-enable generator.
// Optional phase registers are enabled with the CLKEN_PLL_PHASE_EN macro.
package clken_pll_pkg;

    localparam int unsigned DADDR_W  = 4;
    localparam int unsigned DIV_BASE = 0;

    typedef enum logic {
        StLocking = 1'b0,
        StLocked  = 1'b1
    } pll_state_e;

    // Phase registers sit directly above the divider block.
    function automatic int unsigned phase_base(input int unsigned channels);
        return DIV_BASE + channels;
    endfunction

endpackage

// File: rtl/clken_pll_chan.sv
// One clock-enable channel: divider, optional phase, wrap counter and pulse decode.
// Phase register and its write port exist only when CLKEN_PLL_PHASE_EN is defined.
module clken_pll_chan
    import clken_pll_pkg::*;
#(
    parameter int unsigned      DIV_W   = 8,
    parameter logic [DIV_W-1:0] DIV_RST = 1
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             div_we,
`ifdef CLKEN_PLL_PHASE_EN
    input  logic             phase_we,
`endif
    input  logic [DIV_W-1:0] wdata,
    input  logic             locked,
    output logic             clken
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_last;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] load_val;

    always_ff @(posedge refclk) begin
        if (reset) begin
            div_q <= DIV_RST;
        end else if (div_we) begin
            div_q <= wdata;
        end
    end

`ifdef CLKEN_PLL_PHASE_EN
    logic [DIV_W-1:0] phase_q;

    always_ff @(posedge refclk) begin
        if (reset) begin
            phase_q <= '0;
        end else if (phase_we) begin
            phase_q <= wdata;
        end
    end

    // An out-of-range phase would never hit the wrap point, so start at zero instead.
    assign load_val = (phase_q >= div_q) ? '0 : phase_q;
`else
    assign load_val = '0;
`endif

    assign div_last = div_q - 1'b1;

    // While locking the counter tracks its load value, so it is aligned on lock entry.
    always_comb begin
        cnt_d = cnt_q;
        if (!locked) begin
            cnt_d = load_val;
        end else if (cnt_q == div_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clken = locked && (cnt_q == div_last);

endmodule

// File: rtl/clken_pll.sv
// Clock-enable "PLL": programmable per-channel enable pulses gated by a lock timer.
// Define CLKEN_PLL_PHASE_EN to add per-channel phase registers at the upper addresses.
module clken_pll
    import clken_pll_pkg::*;
#(
    parameter int unsigned                   CHANNELS    = 2,
    parameter int unsigned                   DIV_W       = 8,
    parameter int unsigned                   LOCK_CYCLES = 16,
    parameter logic [CHANNELS*DIV_W-1:0]     DIV_INIT    = {8'd20, 8'd5}
) (
    input  logic                refclk,
    input  logic                reset,
    input  logic                dcs,
    input  logic                dwe,
    input  logic [DADDR_W-1:0]  daddr,
    input  logic [DIV_W-1:0]    di,
    output logic                dack,
    output logic                derr,
    output logic [CHANNELS-1:0] clken,
    output logic                extlock
);

    localparam int unsigned   LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    // One extra bit so 2*CHANNELS == 16 is still representable.
    localparam int unsigned   AW        = DADDR_W + 1;
    localparam logic [AW-1:0] PHASE_LO  = AW'(phase_base(CHANNELS));
    localparam logic [AW-1:0] PHASE_HI  = AW'(phase_base(CHANNELS) + CHANNELS);

    pll_state_e           state_q;
    pll_state_e           state_d;
    logic [LCW-1:0]       lock_cnt_q;
    logic [LCW-1:0]       lock_cnt_d;
    logic                 dack_q;
    logic                 derr_q;
    logic                 locked;
    logic [CHANNELS-1:0]  chan_en;
    logic [AW-1:0]        addr_x;
    logic                 wr;
    logic                 is_div;
    logic                 is_phase;
    logic                 accept;
    logic                 reject;

    // Write decode; reset masks the strobe so a simultaneous write is dropped.
    assign addr_x = {1'b0, daddr};
    assign wr     = dcs & dwe & ~reset;
    assign is_div = (addr_x < PHASE_LO);
`ifdef CLKEN_PLL_PHASE_EN
    assign is_phase = (addr_x >= PHASE_LO) && (addr_x < PHASE_HI);
`else
    assign is_phase = 1'b0;
`endif
    assign accept = wr && ((is_div && (|di)) || is_phase);
    assign reject = wr && !accept;

    always_ff @(posedge refclk) begin
        if (reset) begin
            dack_q <= 1'b0;
            derr_q <= 1'b0;
        end else begin
            dack_q <= accept;
            derr_q <= reject;
        end
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state_q    <= StLocking;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (accept) begin
            state_d    = StLocking;
            lock_cnt_d = '0;
        end else begin
            unique case (state_q)
                StLocking: begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = StLocked;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                StLocked: begin
                    state_d = StLocked;
                end
            endcase
        end
    end

    assign locked = (state_q == StLocked);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic div_sel;
        assign div_sel = accept && is_div && (addr_x == AW'(DIV_BASE + i));
`ifdef CLKEN_PLL_PHASE_EN
        logic phase_sel;
        assign phase_sel = accept && is_phase && (addr_x == AW'(phase_base(CHANNELS) + i));
`endif

        clken_pll_chan #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_INIT[i*DIV_W +: DIV_W])
        ) u_chan (
            .refclk   (refclk),
            .reset    (reset),
            .div_we   (div_sel),
`ifdef CLKEN_PLL_PHASE_EN
            .phase_we (phase_sel),
`endif
            .wdata    (di),
            .locked   (locked),
            .clken    (chan_en[i])
        );
    end

    // Outputs are forced quiet for every cycle reset is held, including the first.
    assign extlock = locked & ~reset;
    assign clken   = chan_en & {CHANNELS{~reset}};
    assign dack    = dack_q & ~reset;
    assign derr    = derr_q & ~reset;

endmodule

// File: tb/tb_clken_pll.sv
// Bench for clken_pll: directed scenarios plus random traffic against a cycle-arithmetic model.
module tb_clken_pll;

    localparam int CH = 2;
    localparam int DW = 8;
    localparam int LC = 16;

    logic          refclk = 1'b0;
    logic          reset;
    logic          dcs;
    logic          dwe;
    logic [3:0]    daddr;
    logic [DW-1:0] di;
    logic          dack;
    logic          derr;
    logic [CH-1:0] clken;
    logic          extlock;

    clken_pll u_dut (
        .refclk  (refclk),
        .reset   (reset),
        .dcs     (dcs),
        .dwe     (dwe),
        .daddr   (daddr),
        .di      (di),
        .dack    (dack),
        .derr    (derr),
        .clken   (clken),
        .extlock (extlock)
    );

    always #5 refclk = ~refclk;

    int checks   = 0;
    int failures = 0;

    // Model: registers plus the absolute cycle on which extlock is due to rise.
    int div_init[CH] = '{5, 20};
    int div_m[CH];
    int ph_m[CH];
    int cyc        = 0;
    int lock_start = 0;
    int last_evt   = 0;
    bit dack_p     = 0;
    bit derr_p     = 0;
    bit ext_prev   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int load_of(input int i);
`ifdef CLKEN_PLL_PHASE_EN
        return (ph_m[i] < div_m[i]) ? ph_m[i] : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            div_m[i] = div_init[i];
            ph_m[i]  = 0;
        end
    endtask

    // One refclk cycle: drive, check at the falling edge, then advance the model.
    task automatic step(input bit r, input bit cs, input bit we, input int addr, input int data);
        bit exp_ext;
        int exp_ck;
        bit acc;
        reset = r;
        dcs   = cs;
        dwe   = we;
        daddr = 4'(addr);
        di    = 8'(data);
        @(negedge refclk);

        exp_ext = !r && (cyc >= lock_start);
        exp_ck  = 0;
        for (int i = 0; i < CH; i++) begin
            if (exp_ext && (((cyc - lock_start + load_of(i)) % div_m[i]) == div_m[i] - 1))
                exp_ck |= (1 << i);
        end
        check_eq("extlock", int'(extlock), int'(exp_ext));
        check_eq("clken", int'(clken), exp_ck);
        check_eq("dack", int'(dack), int'(!r && dack_p));
        check_eq("derr", int'(derr), int'(!r && derr_p));
        if (extlock && !ext_prev) check_eq("relock_latency", cyc - last_evt, LC + 1);
        ext_prev = extlock;

        dack_p = 0;
        derr_p = 0;
        if (r) begin
            model_reset();
            lock_start = cyc + 1 + LC;
            last_evt   = cyc;
        end else if (cs && we) begin
            acc = 0;
            if (addr < CH) begin
                if (data != 0) begin
                    acc = 1;
                    div_m[addr] = data;
                end
            end
`ifdef CLKEN_PLL_PHASE_EN
            else if (addr < 2 * CH) begin
                acc = 1;
                ph_m[addr - CH] = data;
            end
`endif
            if (acc) begin
                dack_p     = 1;
                lock_start = cyc + 1 + LC;
                last_evt   = cyc;
            end else begin
                derr_p = 1;
            end
        end

        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, $urandom_range(0, 15), $urandom_range(0, 255));
    endtask

    task automatic wr(input int addr, input int data);
        step(0, 1, 1, addr, data);
    endtask

    initial begin
        int mode;
        int addr;
        int data;
        reset = 1'b1;
        dcs   = 1'b0;
        dwe   = 1'b0;
        daddr = '0;
        di    = '0;
        model_reset();
        @(posedge refclk);
        #1;

        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 3);            // write during reset is dropped
        idle(45);                        // default lock and first pulses

        wr(0, 3);                        // divider rewrite while locked
        idle(40);
        wr(1, 0);                        // zero divider rejected
        idle(30);
        wr(2, 2);                        // phase write (rejected when phases absent)
        idle(40);
        wr(7, 5);                        // out-of-map address
        idle(5);

        wr(0, 5);                        // back-to-back burst
        wr(1, 20);
        wr(3, 1);
        idle(30);

        wr(0, 4);                        // reset mid-lock, then write mid-lock
        idle(10);
        step(1, 0, 0, 0, 0);
        idle(5);
        wr(1, 7);
        idle(25);

        step(0, 1, 0, 0, 9);             // half strobes ignored
        step(0, 0, 1, 1, 9);
        idle(5);

        for (int n = 0; n < 2500; n++) begin
            mode = $urandom_range(0, 59);
            addr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2 * CH - 1);
            data = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 25);
            if ($urandom_range(0, 399) == 0) step(1, mode < 2, mode < 2, addr, data);
            else if (mode < 2) step(0, 1, 1, addr, data);
            else if (mode == 2) step(0, 1, 0, addr, data);
            else if (mode == 3) step(0, 0, 1, addr, data);
            else step(0, 0, 0, addr, data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
